// File: rtl/engine_credit_scoreboard_pkg.sv
// Shared types for the engine credit scoreboard.
// Barrier FSM states and error-flag bit positions.
package engine_credit_scoreboard_pkg;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_WAIT = 1'b1
  } barrier_state_e;

  localparam int ERR_W         = 3;
  localparam int ERR_BAD_ID    = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_TIMEOUT   = 2;

endpackage

// File: rtl/engine_credit_scoreboard_if.sv
// Issue handshake between instruction decode and the scoreboard.
// Decode is the master; the scoreboard answers with ready.
interface engine_credit_scoreboard_if #(
  parameter int ENG_ID_W = 3
);

  logic                issue_valid;
  logic [ENG_ID_W-1:0] issue_engine_id;
  logic                issue_ready;

  modport master (
    output issue_valid,
    output issue_engine_id,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_engine_id,
    output issue_ready
  );

endinterface

// File: rtl/engine_credit_scoreboard_credit_counter.sv
// Per-engine outstanding-command counter.
// Simultaneous inc and dec leave the count unchanged.
module credit_counter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty,
  output logic underflow
);

  logic [CNT_W-1:0] count_q;

  assign full      = count_q == CNT_W'(MAX_OUTSTANDING);
  assign empty     = count_q == '0;
  assign underflow = dec & ~inc & empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc & ~dec & ~full) begin
      count_q <= count_q + 1'b1;
    end else if (dec & ~inc & ~empty) begin
      count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/engine_credit_scoreboard.sv
// Credit scoreboard: per-engine counters, masked barrier with
// watchdog, and sticky protocol-error flags.
module engine_credit_scoreboard
  import engine_credit_scoreboard_pkg::*;
#(
  parameter int NUM_ENGINES     = 8,
  parameter int ENG_ID_W        = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  engine_credit_scoreboard_if.slave issue,
  input  logic [NUM_ENGINES-1:0] engine_done,
  input  logic                   barrier_req,
  input  logic [NUM_ENGINES-1:0] barrier_mask,
  output logic                   barrier_ready,
  output logic                   barrier_done,
  output logic                   barrier_timeout,
  output logic [NUM_ENGINES-1:0] engine_busy,
  output logic [NUM_ENGINES-1:0] engine_full,
  output logic                   all_idle,
  output logic [ERR_W-1:0]       err_flags,
  input  logic                   err_clr
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int WD_W  =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  barrier_state_e         state_q, state_d;
  logic [NUM_ENGINES-1:0] wait_mask_q, wait_mask_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   done_d, to_d;
  logic [ERR_W-1:0]       err_q, err_set;

  logic [NUM_ENGINES-1:0] sel, inc, empty, under, blocked;
  logic                   id_ok, b_wait;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      sel[i] = issue.issue_engine_id == ENG_ID_W'(i);
    end
  end

  assign id_ok  = |sel;
  assign b_wait = state_q == B_WAIT;

  // A full engine still accepts when its done pulse frees a slot
  assign blocked = (engine_full & ~engine_done)
                 | (wait_mask_q & {NUM_ENGINES{b_wait}});

  assign issue.issue_ready = id_ok & ~|(sel & blocked);
  assign inc = sel & {NUM_ENGINES{issue.issue_valid & issue.issue_ready}};

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_cnt
    credit_counter #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING),
      .CNT_W          (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc[g]),
      .dec      (engine_done[g]),
      .full     (engine_full[g]),
      .empty    (empty[g]),
      .underflow(under[g])
    );
  end

  assign engine_busy   = ~empty;
  assign all_idle      = &empty;
  assign barrier_ready = state_q == B_IDLE;
  assign err_flags     = err_q;

  always_comb begin
    state_d     = state_q;
    wait_mask_d = wait_mask_q;
    wd_d        = wd_q;
    done_d      = 1'b0;
    to_d        = 1'b0;
    unique case (state_q)
      B_IDLE: begin
        if (barrier_req) begin
          wait_mask_d = barrier_mask;
          wd_d        = '0;
          state_d     = B_WAIT;
        end
      end
      B_WAIT: begin
        if (~|(wait_mask_q & engine_busy)) begin
          done_d  = 1'b1;
          state_d = B_IDLE;
        end else if (TIMEOUT_CYCLES != 0 &&
                     wd_q == WD_W'(TIMEOUT_CYCLES)) begin
          to_d    = 1'b1;
          state_d = B_IDLE;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  always_comb begin
    err_set                = '0;
    err_set[ERR_BAD_ID]    = issue.issue_valid & ~id_ok;
    err_set[ERR_UNDERFLOW] = |under;
    err_set[ERR_TIMEOUT]   = to_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= B_IDLE;
      wait_mask_q     <= '0;
      wd_q            <= '0;
      barrier_done    <= 1'b0;
      barrier_timeout <= 1'b0;
      err_q           <= '0;
    end else begin
      state_q         <= state_d;
      wait_mask_q     <= wait_mask_d;
      wd_q            <= wd_d;
      barrier_done    <= done_d;
      barrier_timeout <= to_d;
      err_q           <= err_clr ? err_set : (err_q | err_set);
    end
  end

endmodule

// File: tb/tb_engine_credit_scoreboard.sv
// Randomized and directed bench for engine_credit_scoreboard.
// Expected values come from a count-per-engine reference model.
module tb_engine_credit_scoreboard;

  localparam int N   = 6;
  localparam int MAX = 4;
  localparam int TO  = 16;
  localparam int IDW = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] engine_done;
  logic         barrier_req;
  logic [N-1:0] barrier_mask;
  logic         barrier_ready;
  logic         barrier_done;
  logic         barrier_timeout;
  logic [N-1:0] engine_busy;
  logic [N-1:0] engine_full;
  logic         all_idle;
  logic [2:0]   err_flags;
  logic         err_clr;

  engine_credit_scoreboard_if #(.ENG_ID_W(IDW)) bus ();

  engine_credit_scoreboard #(
    .NUM_ENGINES    (N),
    .ENG_ID_W       (IDW),
    .MAX_OUTSTANDING(MAX),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue          (bus),
    .engine_done    (engine_done),
    .barrier_req    (barrier_req),
    .barrier_mask   (barrier_mask),
    .barrier_ready  (barrier_ready),
    .barrier_done   (barrier_done),
    .barrier_timeout(barrier_timeout),
    .engine_busy    (engine_busy),
    .engine_full    (engine_full),
    .all_idle       (all_idle),
    .err_flags      (err_flags),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int           cnt[N];
  bit           bwait;
  logic [N-1:0] wmask;
  int           wd;
  logic [2:0]   merr;

  logic [19:0] rst_vec;
  assign rst_vec = {bus.issue_ready, barrier_ready, barrier_done,
                    barrier_timeout, all_idle, engine_busy,
                    engine_full, err_flags};

  task automatic model_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    bwait = 1'b0;
    wmask = '0;
    wd    = 0;
    merr  = '0;
  endtask

  task automatic idle_inputs();
    bus.issue_valid     = 1'b0;
    bus.issue_engine_id = '0;
    engine_done         = '0;
    barrier_req         = 1'b0;
    barrier_mask        = '0;
    err_clr             = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // One clock: drive, check ready, advance model, check outputs
  task automatic step(input bit v, input int id, input logic [N-1:0] dn,
                      input bit req, input logic [N-1:0] msk,
                      input bit clr, output bit rdy);
    bit exp_rdy, acc, xdone, xto, drained;
    logic [2:0] set;
    logic [N-1:0] xbusy, xfull;
    bus.issue_valid     = v;
    bus.issue_engine_id = IDW'(id);
    engine_done         = dn;
    barrier_req         = req;
    barrier_mask        = msk;
    err_clr             = clr;
    #1;
    exp_rdy = 1'b0;
    if (id < N) begin
      exp_rdy = (cnt[id] < MAX || dn[id]) && !(bwait && wmask[id]);
    end
    rdy = bus.issue_ready;
    n_tests++;
    if (rdy !== exp_rdy) begin
      n_fail++;
      $display("FAIL issue_ready cyc=%0d id=%0d got=%b exp=%b",
               cyc, id, rdy, exp_rdy);
    end
    acc = v && exp_rdy;
    set = '0;
    if (v && id >= N) set[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (dn[i] && cnt[i] == 0 && !(acc && id == i)) set[1] = 1'b1;
    end
    xdone = 1'b0;
    xto   = 1'b0;
    if (!bwait) begin
      if (req) begin
        bwait = 1'b1;
        wmask = msk;
        wd    = 0;
      end
    end else begin
      drained = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (wmask[i] && cnt[i] != 0) drained = 1'b0;
      end
      if (drained) begin
        xdone = 1'b1;
        bwait = 1'b0;
      end else if (wd >= TO) begin
        xto    = 1'b1;
        set[2] = 1'b1;
        bwait  = 1'b0;
      end else begin
        wd++;
      end
    end
    for (int i = 0; i < N; i++) begin
      cnt[i] = cnt[i] + ((acc && id == i) ? 1 : 0) - (dn[i] ? 1 : 0);
      if (cnt[i] < 0) cnt[i] = 0;
    end
    merr = clr ? set : (merr | set);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      xbusy[i] = cnt[i] != 0;
      xfull[i] = cnt[i] == MAX;
    end
    n_tests++;
    if (engine_busy !== xbusy) begin
      n_fail++;
      $display("FAIL engine_busy cyc=%0d got=%b exp=%b",
               cyc, engine_busy, xbusy);
    end
    n_tests++;
    if (engine_full !== xfull) begin
      n_fail++;
      $display("FAIL engine_full cyc=%0d got=%b exp=%b",
               cyc, engine_full, xfull);
    end
    n_tests++;
    if (all_idle !== (xbusy == '0)) begin
      n_fail++;
      $display("FAIL all_idle cyc=%0d got=%b exp=%b",
               cyc, all_idle, (xbusy == '0));
    end
    n_tests++;
    if (err_flags !== merr) begin
      n_fail++;
      $display("FAIL err_flags cyc=%0d got=%b exp=%b",
               cyc, err_flags, merr);
    end
    n_tests++;
    if (barrier_done !== xdone) begin
      n_fail++;
      $display("FAIL barrier_done cyc=%0d got=%b exp=%b",
               cyc, barrier_done, xdone);
    end
    n_tests++;
    if (barrier_timeout !== xto) begin
      n_fail++;
      $display("FAIL barrier_timeout cyc=%0d got=%b exp=%b",
               cyc, barrier_timeout, xto);
    end
    n_tests++;
    if (barrier_ready !== !bwait) begin
      n_fail++;
      $display("FAIL barrier_ready cyc=%0d got=%b exp=%b",
               cyc, barrier_ready, !bwait);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (rst_vec !== {5'b11001, 15'b0}) begin
      n_fail++;
      $display("FAIL reset_values got=%h exp=%h", rst_vec, {5'b11001, 15'b0});
    end
  endtask

  task automatic test_fill();
    bit r;
    do_reset();
    for (int k = 0; k < MAX; k++) begin
      step(1, 2, '0, 0, '0, 0, r);
      n_tests++;
      if (engine_busy[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_busy k=%0d got=%b exp=1", k, engine_busy[2]);
      end
    end
    n_tests++;
    if (engine_full[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full got=%b exp=1", engine_full[2]);
    end
    step(1, 2, '0, 0, '0, 0, r);
    n_tests++;
    if (r !== 1'b0) begin
      n_fail++;
      $display("FAIL fifth_issue_ready got=%b exp=0", r);
    end
  endtask

  task automatic test_same_cycle();
    bit r;
    step(1, 2, 6'b000100, 0, '0, 0, r);
    n_tests++;
    if (engine_full[2] !== 1'b1 || err_flags !== 3'b000) begin
      n_fail++;
      $display("FAIL same_cycle full=%b err=%b exp full=1 err=000",
               engine_full[2], err_flags);
    end
  endtask

  task automatic test_underflow();
    bit r;
    do_reset();
    step(0, 0, 6'b100000, 0, '0, 0, r);
    n_tests++;
    if (err_flags !== 3'b010) begin
      n_fail++;
      $display("FAIL underflow_err got=%b exp=010", err_flags);
    end
    step(0, 0, '0, 0, '0, 1, r);
    n_tests++;
    if (err_flags !== 3'b000 || engine_busy[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_clr err=%b busy5=%b exp 000/0",
               err_flags, engine_busy[5]);
    end
  endtask

  task automatic test_barrier();
    bit r;
    int seen, pulses;
    logic [N-1:0] dn;
    do_reset();
    step(1, 1, '0, 0, '0, 0, r);
    step(1, 3, '0, 0, '0, 0, r);
    step(0, 0, '0, 1, 6'h0A, 0, r);
    seen   = -1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      dn = '0;
      if (k == 3) dn[1] = 1'b1;
      if (k == 7) dn[3] = 1'b1;
      if (k == 2) begin
        step(1, 1, dn, 0, '0, 0, r);
        n_tests++;
        if (r !== 1'b0) begin
          n_fail++;
          $display("FAIL masked_issue_blocked got=%b exp=0", r);
        end
      end else if (k == 4) begin
        step(1, 0, dn, 0, '0, 0, r);
        n_tests++;
        if (r !== 1'b1) begin
          n_fail++;
          $display("FAIL unmasked_issue got=%b exp=1", r);
        end
      end else begin
        step(0, 0, dn, 0, '0, 0, r);
      end
      if (barrier_done === 1'b1) begin
        pulses++;
        if (seen < 0) seen = k;
      end
    end
    n_tests++;
    if (pulses != 1 || seen != 8) begin
      n_fail++;
      $display("FAIL barrier_drain pulses=%0d at=%0d exp 1 at 8",
               pulses, seen);
    end
  endtask

  task automatic test_timeout();
    bit r;
    int seen;
    do_reset();
    step(1, 4, '0, 0, '0, 0, r);
    step(0, 0, '0, 1, 6'h10, 0, r);
    seen = -1;
    for (int k = 1; k <= 40 && seen < 0; k++) begin
      step(0, 0, '0, 0, '0, 0, r);
      if (barrier_timeout === 1'b1) seen = k;
    end
    n_tests++;
    if (seen != TO + 1 || err_flags[2] !== 1'b1 || barrier_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout at=%0d err=%b rdy=%b exp at=%0d err=1xx rdy=1",
               seen, err_flags, barrier_ready, TO + 1);
    end
  endtask

  task automatic test_bad_id();
    bit r;
    do_reset();
    step(1, 7, '0, 0, '0, 0, r);
    n_tests++;
    if (r !== 1'b0 || err_flags !== 3'b001 || all_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_id rdy=%b err=%b idle=%b exp 0/001/1",
               r, err_flags, all_idle);
    end
  endtask

  task automatic test_reset_mid();
    bit r;
    do_reset();
    step(1, 1, '0, 0, '0, 0, r);
    step(1, 1, '0, 0, '0, 0, r);
    step(0, 0, 6'b100000, 1, 6'h02, 0, r);
    step(0, 0, '0, 0, '0, 0, r);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rst_vec !== {5'b11001, 15'b0}) begin
      n_fail++;
      $display("FAIL reset_mid got=%h exp=%h", rst_vec, {5'b11001, 15'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step(0, 0, '0, 0, '0, 0, r);
  endtask

  task automatic test_random();
    bit r;
    int id;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      id = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7)
                                       : $urandom_range(0, 5);
      step(bit'($urandom_range(0, 1)), id,
           N'($urandom & $urandom),
           $urandom_range(0, 11) == 0, N'($urandom),
           $urandom_range(0, 15) == 0, r);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_same_cycle();
    test_underflow();
    test_barrier();
    test_timeout();
    test_bad_id();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
